// File: rtl/ex_muldiv_if.sv
// Operand, sub-opcode and HI/LO result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if;
    logic        flush;
    logic [2:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output flush, md_op, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  flush, md_op, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is applied when the result is written.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    ex_muldiv_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        is_div_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic [31:0] opnd_q;
    logic [31:0] dvd_raw_q;
    logic [63:0] work_q, work_d;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        start, mt_hi, mt_lo, finish;
    logic        op_is_div, op_is_sgn;
    logic [32:0] sum_m;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn_op);
        return (sgn_op && (v < 0)) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.flush) begin
                    case (bus.md_op)
                        3'd1, 3'd2, 3'd3, 3'd4: begin
                            start   = 1'b1;
                            state_d = RUN;
                        end
                        3'd5:    mt_hi = 1'b1;
                        3'd6:    mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'd31) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign op_is_div = (bus.md_op == 3'd3) || (bus.md_op == 3'd4);
    assign op_is_sgn = (bus.md_op == 3'd1) || (bus.md_op == 3'd3);

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        sum_m   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
        shifted = {work_q[63:32], work_q[31]};
        ge      = (shifted >= {1'b0, opnd_q});
        diff    = shifted - {1'b0, opnd_q};
        if (is_div_q) begin
            work_d = {(ge ? diff[31:0] : shifted[31:0]), work_q[30:0], ge};
        end else begin
            work_d = {sum_m, work_q[31:1]};
        end
    end

    assign prod_fix = neg64(work_d, neg_res_q);
    assign quot_fix = neg32(work_d[31:0], neg_res_q);
    assign rem_fix  = neg32(work_d[63:32], neg_rem_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= 32'd0;
            dvd_raw_q <= 32'd0;
            work_q    <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            if (start) begin
                cnt_q     <= 5'd0;
                is_div_q  <= op_is_div;
                neg_res_q <= op_is_sgn & (bus.op_a[31] ^ bus.op_b[31]);
                neg_rem_q <= op_is_sgn & bus.op_a[31];
                dvd_raw_q <= bus.op_a;
                if (op_is_div) begin
                    work_q <= {32'd0, mag32(bus.op_a, op_is_sgn)};
                    opnd_q <= mag32(bus.op_b, op_is_sgn);
                end else begin
                    work_q <= {32'd0, mag32(bus.op_b, op_is_sgn)};
                    opnd_q <= mag32(bus.op_a, op_is_sgn);
                end
            end else if (state_q == RUN) begin
                work_q <= work_d;
                cnt_q  <= cnt_q + 5'd1;
            end
            if (mt_hi) hi_q <= bus.op_a;
            if (mt_lo) lo_q <= bus.op_a;
            // Division by zero still runs all iterations; the result is substituted here.
            if (finish) begin
                if (!is_div_q) begin
                    hi_q <= prod_fix[63:32];
                    lo_q <= prod_fix[31:0];
                end else if (opnd_q == 32'd0) begin
                    hi_q <= dvd_raw_q;
                    lo_q <= 32'hFFFF_FFFF;
                end else begin
                    hi_q <= rem_fix;
                    lo_q <= quot_fix;
                end
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit for the execute stage, directly downstream of the ID/EX pipeline register. It consumes the forwarded operand values and the multiply/divide sub-opcode for the instruction currently in EX. It computes MULT/MULTU/DIV/DIVU results into the architectural HI/LO registers over 32 cycles, and writes HI/LO directly for MTHI/MTLO. While an operation is in flight it raises `busy`, which hazard control uses to stall the ID/EX register for any later HI/LO consumer.

## Interface
Parameters:
- none (fixed 32-bit datapath, fixed 32 iterations)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  pipeline flush: aborts any in-flight operation and blocks any start in the same cycle.
- `md_op`  in  3  0 = none, 1 = MULT, 2 = MULTU, 3 = DIV, 4 = DIVU, 5 = MTHI, 6 = MTLO, 7 = reserved (treated as none).
- `op_a`  in  32  rs value after forwarding: multiplicand, dividend, or MTHI/MTLO source.
- `op_b`  in  32  rt value after forwarding: multiplier or divisor.
- `busy`  out  1  operation in flight; HI/LO not valid.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO take a MULT/DIV result.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- States: IDLE and RUN. Iteration counter is 5 bits, range 0..31.
- Reset while `rst_n` = 0, asynchronous and immediate:
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.
  - State = IDLE, counter = 0, internal working registers cleared.
- In IDLE, with `flush` = 0, at the edge:
  - `md_op` 1–4: latch operands and operation type, state → RUN, counter = 0.
  - `md_op` 5: `hi` ← `op_a`. Single cycle; `busy` is not asserted.
  - `md_op` 6: `lo` ← `op_a`. Single cycle; `busy` is not asserted.
- Signed operations (MULT, DIV) run on the magnitudes of both operands. The sign is fixed up at completion.
- Multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
  - Result is the exact 64-bit product, two's complement for MULT.
  - `hi` = product[63:32], `lo` = product[31:0].
- Divide: restoring, one quotient bit per cycle.
  - `lo` = quotient, truncated toward zero.
  - `hi` = remainder, which takes the sign of the dividend.
- Divide by zero: no trap, still 32 cycles. Result is `hi` = `op_a` (as latched) and `lo` = 0xFFFFFFFF, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0. Magnitude arithmetic yields this naturally.
- In RUN:
  - `md_op` is ignored; hazard control must stall.
  - On the edge where counter = 31: `hi`/`lo` are written, state → IDLE, `done` is set for the next cycle.
- `flush` in RUN: state → IDLE at that edge. `hi`/`lo` are unchanged and no `done` pulse is produced.
- `flush` in IDLE: that cycle's `md_op` has no effect, including MTHI/MTLO.
- `busy` is high exactly when state = RUN. It is a registered signal with no combinational path from the inputs.

## Timing
- Start edge E0: `busy` is high from the cycle after E0 through edge E32. That is 32 cycles high.
- `hi`/`lo` change at E32. The new values are visible and `done` = 1 in the cycle after E32.
- `done` falls at E33.
- A new MULT/DIV may be started at E32 itself, because state is IDLE in the cycle preceding E32? No: state is IDLE only after E32, so the earliest new start edge is E33. Back-to-back operations are therefore 33 edges apart.
- MTHI/MTLO: latency 1. The value is visible in the cycle after the sampling edge.
- Reset assertion mid-RUN forces every output to its reset value without waiting for a clock edge. After `rst_n` deasserts, the first edge is an IDLE edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - `busy` is high for exactly 32 cycles.
  - Then `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
  - `done` is a single 1-cycle pulse.
- MULT:
  - −3 × 7 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
  - 0x80000000 × 0x80000000 → `hi` = 0x40000000, `lo` = 0.
- DIV and DIVU:
  - DIV −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - DIVU 100 / 7 → `lo` = 14, `hi` = 2.
  - DIV 7 / −2 → `lo` = 0xFFFFFFFD, `hi` = 1.
- Corner cases:
  - DIVU 5 / 0 → `hi` = 5, `lo` = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- MULT 2 × 3 with `flush` asserted on the 10th RUN edge:
  - `busy` is low from the next cycle.
  - `hi`/`lo` keep their prior values and no `done` pulse occurs.
  - A DIVU driven on `md_op` during RUN has no effect.
- Reset and MTHI/MTLO:
  - Pulse `rst_n` low mid-RUN: `busy`, `hi`, `lo` are 0 immediately.
  - MTHI 0x1234 while idle → `hi` = 0x1234 next cycle, with `busy` low throughout.
  - MTLO issued together with `flush` → `lo` is unchanged.
